// File: rtl/multicycle_ctrl_if.sv
// Control-unit bundle between the instruction register/datapath and multicycle_ctrl.
// master = control unit side, slave = datapath side.
interface multicycle_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [31:0]      instr;
    logic             zero;
    logic             carry;
    logic             sign;
    logic             overflow;
    logic             mem_ready;

    logic             mem_req;
    logic             adr_src;
    logic             mem_write;
    logic             ir_write;
    logic             reg_write;
    logic             pc_write;
    logic [1:0]       result_src;
    logic [1:0]       alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic [2:0]       state;
    logic             retire;
    logic [CNT_W-1:0] retired_count;
    logic             illegal;

    modport master (
        input  instr, zero, carry, sign, overflow, mem_ready,
        output mem_req, adr_src, mem_write, ir_write, reg_write, pc_write,
               result_src, alu_src_a, alu_src_b, alu_op, state, retire,
               retired_count, illegal
    );

    modport slave (
        output instr, zero, carry, sign, overflow, mem_ready,
        input  mem_req, adr_src, mem_write, ir_write, reg_write, pc_write,
               result_src, alu_src_a, alu_src_b, alu_op, state, retire,
               retired_count, illegal
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control unit: variable-length instruction sequencing with
// memory-ready stalls, optional JALR, illegal-opcode trap and a retire counter.
module multicycle_ctrl #(
    parameter int CNT_W         = 32,
    parameter bit SUPPORT_JALR  = 1'b1,
    parameter bit MEM_HANDSHAKE = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    multicycle_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEM     = 3'd3,
        S_MEMWB   = 3'd4,
        S_ALUWB   = 3'd5,
        S_TRAP    = 3'd7
    } state_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] retired_count_q, retired_count_d;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       ready;
    logic       legal;
    logic       branch_taken;

    logic       mem_req_c, mem_write_c, ir_write_c, reg_write_c, pc_write_c, retire_c;
    logic       adr_src_c;
    logic [1:0] result_src_c, alu_src_a_c, alu_src_b_c, alu_op_c;

    logic       unused_instr_bits;

    assign opcode            = bus.instr[6:0];
    assign funct3            = bus.instr[14:12];
    assign unused_instr_bits = &{1'b0, bus.instr[31:15], bus.instr[11:7]};
    assign ready             = MEM_HANDSHAKE ? bus.mem_ready : 1'b1;

    always_comb begin
        case (opcode)
            OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE,
            OP_JAL, OP_BRANCH, OP_LUI, OP_AUIPC: legal = 1'b1;
            OP_JALR:                             legal = SUPPORT_JALR;
            default:                             legal = 1'b0;
        endcase
    end

    always_comb begin
        case (funct3)
            3'b000:  branch_taken = bus.zero;
            3'b001:  branch_taken = !bus.zero;
            3'b100:  branch_taken = bus.sign ^ bus.overflow;
            3'b101:  branch_taken = !(bus.sign ^ bus.overflow);
            3'b110:  branch_taken = bus.carry;
            3'b111:  branch_taken = !bus.carry;
            default: branch_taken = 1'b0;
        endcase
    end

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves one unassigned (no latches).
        state_d      = state_q;
        mem_req_c    = 1'b0;
        mem_write_c  = 1'b0;
        ir_write_c   = 1'b0;
        reg_write_c  = 1'b0;
        pc_write_c   = 1'b0;
        retire_c     = 1'b0;
        adr_src_c    = 1'b0;
        result_src_c = 2'b00;
        alu_src_a_c  = 2'b00;
        alu_src_b_c  = 2'b00;
        alu_op_c     = 2'b00;

        case (state_q)
            S_FETCH: begin
                mem_req_c    = 1'b1;
                alu_src_b_c  = 2'b10;
                result_src_c = 2'b10;
                ir_write_c   = ready;
                pc_write_c   = ready;
                if (ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a_c = 2'b01;
                alu_src_b_c = 2'b01;
                state_d     = legal ? S_EXECUTE : S_TRAP;
            end
            S_EXECUTE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: begin
                        alu_src_a_c = 2'b10;
                        alu_src_b_c = 2'b01;
                        state_d     = S_MEM;
                    end
                    OP_RTYPE, OP_ITYPE: begin
                        alu_src_a_c = 2'b10;
                        alu_src_b_c = (opcode == OP_ITYPE) ? 2'b01 : 2'b00;
                        alu_op_c    = 2'b10;
                        state_d     = S_ALUWB;
                    end
                    OP_JAL: begin
                        alu_src_a_c = 2'b01;
                        alu_src_b_c = 2'b10;
                        pc_write_c  = 1'b1;
                        state_d     = S_ALUWB;
                    end
                    OP_JALR: begin
                        alu_src_a_c  = 2'b10;
                        alu_src_b_c  = 2'b01;
                        result_src_c = 2'b10;
                        pc_write_c   = 1'b1;
                        state_d      = S_ALUWB;
                    end
                    OP_BRANCH: begin
                        alu_src_a_c = 2'b10;
                        alu_op_c    = 2'b01;
                        pc_write_c  = branch_taken;
                        retire_c    = 1'b1;
                        state_d     = S_FETCH;
                    end
                    OP_LUI: begin
                        alu_src_b_c  = 2'b01;
                        alu_op_c     = 2'b11;
                        result_src_c = 2'b10;
                        reg_write_c  = 1'b1;
                        retire_c     = 1'b1;
                        state_d      = S_FETCH;
                    end
                    OP_AUIPC: begin
                        alu_src_a_c  = 2'b01;
                        alu_src_b_c  = 2'b01;
                        result_src_c = 2'b10;
                        reg_write_c  = 1'b1;
                        retire_c     = 1'b1;
                        state_d      = S_FETCH;
                    end
                    default: state_d = S_TRAP;
                endcase
            end
            S_MEM: begin
                mem_req_c   = 1'b1;
                adr_src_c   = 1'b1;
                mem_write_c = (opcode == OP_STORE);
                if (ready) begin
                    if (opcode == OP_LOAD) begin
                        state_d = S_MEMWB;
                    end else begin
                        retire_c = 1'b1;
                        state_d  = S_FETCH;
                    end
                end
            end
            S_MEMWB: begin
                result_src_c = 2'b01;
                reg_write_c  = 1'b1;
                retire_c     = 1'b1;
                state_d      = S_FETCH;
            end
            S_ALUWB: begin
                reg_write_c = 1'b1;
                retire_c    = 1'b1;
                state_d     = S_FETCH;
                // JALR writes the link address OldPC+4 now that PC already holds the target
                if (opcode == OP_JALR) begin
                    alu_src_a_c  = 2'b01;
                    alu_src_b_c  = 2'b10;
                    result_src_c = 2'b10;
                end
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase
    end

    assign retired_count_d = retire_c ? retired_count_q + CNT_W'(1) : retired_count_q;

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset) begin
            state_q         <= S_FETCH;
            retired_count_q <= '0;
        end else begin
            state_q         <= state_d;
            retired_count_q <= retired_count_d;
        end
    end

    // Enables are held off combinationally for the whole reset pulse, not just after the edge.
    assign bus.mem_req       = mem_req_c   & ~reset;
    assign bus.mem_write     = mem_write_c & ~reset;
    assign bus.ir_write      = ir_write_c  & ~reset;
    assign bus.reg_write     = reg_write_c & ~reset;
    assign bus.pc_write      = pc_write_c  & ~reset;
    assign bus.retire        = retire_c    & ~reset;
    assign bus.adr_src       = adr_src_c;
    assign bus.result_src    = result_src_c;
    assign bus.alu_src_a     = alu_src_a_c;
    assign bus.alu_src_b     = alu_src_b_c;
    assign bus.alu_op        = alu_op_c;
    assign bus.state         = state_q;
    assign bus.retired_count = retired_count_q;
    assign bus.illegal       = (state_q == S_TRAP);

endmodule
